vga_timing: RTL

Pixel-clock and raster timing generator for the debug display. It divides the board clock down to a pixel tick and produces the `x`/`y` scan coordinates consumed by the combinational screen renderer. It samples the renderer's colour answer back, applies blanking, and drives registered `r`/`g`/`b` plus `hs`/`vs` to the VGA connector with sync and colour aligned. Default geometry is 640x480@60 Hz from a 50 MHz clock.

---
 rtl/vga_timing.sv | 100 ++++++++++
 1 files changed

// File: rtl/vga_timing.sv
// Raster timing generator: divides the board clock to a pixel tick, scans x/y,
// and registers blanked colour plus active-low hs/vs one pixel behind x/y.
module vga_timing #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] x,
  output logic [10:0] y,
  input  logic [2:0]  r_in,
  input  logic [2:0]  g_in,
  input  logic [2:0]  b_in,
  output logic [2:0]  r,
  output logic [2:0]  g,
  output logic [2:0]  b,
  output logic        hs,
  output logic        vs,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEGIN   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEGIN   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic [10:0]   hcnt;
  logic [10:0]   vcnt;
  logic          tick;
  logic          h_wrap;
  logic          v_wrap;
  logic          active;
  logic          hs_next;
  logic          vs_next;

  // With CLK_DIV=1 the divider is a constant 0 and every clock is a tick.
  assign tick    = (div_cnt == DIV_LAST);
  assign h_wrap  = (hcnt == H_LAST);
  assign v_wrap  = (vcnt == V_LAST);
  assign active  = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign hs_next = !((hcnt >= HS_BEGIN) && (hcnt < HS_END));
  assign vs_next = !((vcnt >= VS_BEGIN) && (vcnt < VS_END));

  assign x = hcnt;
  assign y = vcnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt     <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      div_cnt     <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        // Outputs describe the pixel being left, keeping colour and sync aligned.
        r  <= active ? r_in : 3'd0;
        g  <= active ? g_in : 3'd0;
        b  <= active ? b_in : 3'd0;
        hs <= hs_next;
        vs <= vs_next;
        if (h_wrap) begin
          hcnt <= '0;
          if (v_wrap) begin
            vcnt        <= '0;
            frame_start <= 1'b1;
          end else begin
            vcnt <= vcnt + 11'd1;
          end
        end else begin
          hcnt <= hcnt + 11'd1;
        end
      end
    end
  end

endmodule
